// File: rtl/waveform_shape_gen_if.sv
// Control and sample bus between the DAC timing stage and the waveform generator.
// The timing stage drives the step request and shape/amplitude selects; the generator returns the DAC word and strobes.
interface waveform_shape_gen_if #(
  parameter int DATA_W = 12
) ();
  logic              dbClock;
  logic              En;
  logic [1:0]        Shape;
  logic [1:0]        Amp;
  logic [DATA_W-1:0] DB;
  logic              Sample_strobe;
  logic              Period_start;

  modport master (
    output dbClock, En, Shape, Amp,
    input  DB, Sample_strobe, Period_start
  );

  modport slave (
    input  dbClock, En, Shape, Amp,
    output DB, Sample_strobe, Period_start
  );
endinterface

// File: rtl/waveform_shape_gen.sv
// DAC sample generator: each falling edge of the asynchronous dbClock advances a phase counter
// and registers the next square/saw/triangle/sine sample, attenuated around mid-scale.
module waveform_shape_gen #(
  parameter int DATA_W  = 12,
  parameter int PHASE_W = 8
) (
  input logic                 Clk,
  input logic                 Rst,
  waveform_shape_gen_if.slave bus
);
  localparam int LUT_AW = 6;
  localparam logic [DATA_W-1:0] MID_HI = DATA_W'(1) << (DATA_W - 1);
  localparam logic [DATA_W-1:0] MID_LO = MID_HI - DATA_W'(1);
  localparam logic [DATA_W:0]   FULL   = (DATA_W + 1)'(1) << DATA_W;

  // First quarter-wave of a 2047-peak sine, sampled at bin centres.
  localparam logic [10:0] SINE_LUT [64] = '{
    11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
    11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
    11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
    11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
    11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
    11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
    11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
    11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
  };

  logic               s1, s2, s3;
  logic               fall;
  logic               advance;
  logic [PHASE_W-1:0] phase;
  logic               at_period_start;
  logic [1:0]         active_shape, active_amp;
  logic [1:0]         sel_shape, sel_amp;
  logic [DATA_W-1:0]  db_q;
  logic               strobe_q;
  logic               period_start_q;

  logic [PHASE_W-2:0] tri_t;
  logic [DATA_W-1:0]  square_raw, saw_raw, tri_raw, sine_raw, raw;
  logic [1:0]         quad;
  logic [PHASE_W-3:0] qidx;
  logic [LUT_AW-1:0]  lut_idx;
  logic [DATA_W-1:0]  mag;
  logic [DATA_W:0]    part_scale;
  logic [DATA_W:0]    offset_w;
  logic [DATA_W-1:0]  scaled;

  // dbClock idles high, so the sync chain resets to 1 to avoid a phantom fall.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= bus.dbClock;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall            = s3 & ~s2;
  assign advance         = fall & bus.En;
  assign at_period_start = (phase == '0);

  // Shape/amp are only picked up at phase 0 so a period is never mixed.
  assign sel_shape = at_period_start ? bus.Shape : active_shape;
  assign sel_amp   = at_period_start ? bus.Amp   : active_amp;

  assign square_raw = phase[PHASE_W-1] ? '0 : '1;
  assign tri_t      = phase[PHASE_W-1] ? ~phase[PHASE_W-2:0] : phase[PHASE_W-2:0];

  // Left-align the ramp and fill the low bits with its own MSBs so full scale is reachable.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fill
    assign saw_raw[gi] = phase[PHASE_W-1 - ((DATA_W-1-gi) % PHASE_W)];
    assign tri_raw[gi] = tri_t[PHASE_W-2 - ((DATA_W-1-gi) % (PHASE_W-1))];
  end

  assign quad     = phase[PHASE_W-1 -: 2];
  assign qidx     = quad[0] ? ~phase[PHASE_W-3:0] : phase[PHASE_W-3:0];
  assign lut_idx  = qidx[PHASE_W-3 -: LUT_AW];
  assign mag      = DATA_W'(SINE_LUT[lut_idx]);
  assign sine_raw = quad[1] ? (MID_LO - mag) : (MID_HI + mag);

  always_comb begin
    raw = square_raw;
    case (sel_shape)
      2'b00:   raw = square_raw;
      2'b01:   raw = saw_raw;
      2'b10:   raw = tri_raw;
      default: raw = sine_raw;
    endcase
  end

  // Offset recentres the attenuated wave on mid-scale; sum never exceeds full scale.
  always_comb begin
    part_scale = FULL >> sel_amp;
    offset_w   = FULL - part_scale;
    scaled     = (raw >> sel_amp) + offset_w[DATA_W:1];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase          <= '0;
      active_shape   <= 2'b00;
      active_amp     <= 2'b00;
      db_q           <= '0;
      strobe_q       <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      strobe_q       <= advance;
      period_start_q <= advance & at_period_start;
      if (advance) begin
        db_q  <= scaled;
        phase <= phase + PHASE_W'(1);
        if (at_period_start) begin
          active_shape <= bus.Shape;
          active_amp   <= bus.Amp;
        end
      end
    end
  end

  assign bus.DB            = db_q;
  assign bus.Sample_strobe = strobe_q;
  assign bus.Period_start  = period_start_q;
endmodule

// File: tb/tb_waveform_shape_gen.sv
// Scoreboard bench for waveform_shape_gen: stimulus pushes model samples, a negedge monitor pops them.
module tb_waveform_shape_gen;
  localparam int DATA_W  = 12;
  localparam int PHASE_W = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  waveform_shape_gen_if #(.DATA_W(DATA_W)) bus ();

  waveform_shape_gen #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int db;
    bit ps;
    int ph;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   lut[64];
  int   m_phase = 0;
  int   m_shape = 0;
  int   m_amp   = 0;
  int   last_db = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_sample(input int shape, input int amp, input int p);
    int raw, t, q, i, idx;
    case (shape)
      0: raw = (p < 128) ? 4095 : 0;
      1: raw = (p << 4) | (p >> 4);
      2: begin
        t   = (p >= 128) ? 255 - p : p;
        raw = (t << 5) | (t >> 2);
      end
      default: begin
        q   = p / 64;
        i   = p % 64;
        idx = (q % 2 == 1) ? 63 - i : i;
        raw = (q >= 2) ? 2047 - lut[idx] : 2048 + lut[idx];
      end
    endcase
    return (raw >> amp) + ((4096 - (4096 >> amp)) >> 1);
  endfunction

  task automatic model_advance();
    exp_t e;
    if (m_phase == 0) begin
      m_shape = int'(bus.Shape);
      m_amp   = int'(bus.Amp);
    end
    e.db    = model_sample(m_shape, m_amp, m_phase);
    e.ps    = (m_phase == 0);
    e.ph    = m_phase;
    last_db = e.db;
    sb.push_back(e);
    m_phase = (m_phase + 1) % 256;
  endtask

  // One dbClock low pulse of low_cycles clocks followed by an idle-high gap.
  task automatic step(input int low_cycles);
    @(posedge Clk);
    #1 bus.dbClock = 1'b0;
    if (bus.En) model_advance();
    repeat (low_cycles) @(posedge Clk);
    #1 bus.dbClock = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step(1);
  endtask

  always @(negedge Clk) begin
    if (Rst) begin
      if (bus.Sample_strobe) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: DB=%0d, no sample expected", bus.DB);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("db_p%0d", mon_e.ph), int'(bus.DB), mon_e.db);
          check($sformatf("period_start_p%0d", mon_e.ph), int'(bus.Period_start), int'(mon_e.ps));
        end
      end else begin
        check("stray_period_start", int'(bus.Period_start), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++)
      lut[k] = $rtoi($floor(2047.0 * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / 64.0) + 0.5));

    bus.dbClock = 1'b1;
    bus.En      = 1'b1;
    bus.Shape   = 2'b01;
    bus.Amp     = 2'b00;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_db", int'(bus.DB), 0);
    check("reset_strobe", int'(bus.Sample_strobe), 0);
    check("reset_period_start", int'(bus.Period_start), 0);
    @(negedge Clk) Rst = 1'b1;

    // Sawtooth full period
    run(1);   check("saw_p0", int'(bus.DB), 0);
    run(1);   check("saw_p1", int'(bus.DB), 16);
    run(254); check("saw_p255", int'(bus.DB), 4095);

    // Square at full and 1/8 amplitude
    bus.Shape = 2'b00;
    run(1);   check("sq_p0", int'(bus.DB), 4095);
    run(127); check("sq_p127", int'(bus.DB), 4095);
    run(1);   check("sq_p128", int'(bus.DB), 0);
    run(127);
    bus.Amp = 2'b11;
    run(1);   check("sq_a3_hi", int'(bus.DB), 2303);
    run(127);
    run(1);   check("sq_a3_lo", int'(bus.DB), 1792);
    run(127);

    // Sine
    bus.Shape = 2'b11;
    bus.Amp   = 2'b00;
    run(1);   check("sine_p0", int'(bus.DB), 2073);
    run(64);  check("sine_p64", int'(bus.DB), 4095);
    run(128); check("sine_p192", int'(bus.DB), 0);
    run(63);

    // Shape change mid-period only takes effect at the next phase 0
    bus.Shape = 2'b01;
    run(100); check("saw_p99", int'(bus.DB), 1590);
    bus.Shape = 2'b10;
    run(156); check("saw_cont_p255", int'(bus.DB), 4095);
    run(1);   check("tri_p0", int'(bus.DB), 0);
    run(127); check("tri_p127", int'(bus.DB), 4095);
    run(128);

    // Short and long low pulses, then a fall with En low
    bus.Shape = 2'b01;
    step(1);
    step(50); check("long_low_p1", int'(bus.DB), 16);
    bus.En = 1'b0;
    step(1);  check("en0_hold_db", int'(bus.DB), last_db);
    bus.En = 1'b1;
    run(1);   check("en0_phase_held", int'(bus.DB), 32);

    // Reset in mid-period
    run(74);  check("saw_p76", int'(bus.DB), 1220);
    @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    check("midrst_db", int'(bus.DB), 0);
    check("midrst_strobe", int'(bus.Sample_strobe), 0);
    check("midrst_period_start", int'(bus.Period_start), 0);
    check("midrst_sb_empty", sb.size(), 0);
    m_phase = 0;
    m_shape = 0;
    m_amp   = 0;
    last_db = 0;
    @(negedge Clk) Rst = 1'b1;
    bus.Shape = 2'b10;
    run(1);   check("post_rst_tri_p0", int'(bus.DB), 0);
    run(2);   check("post_rst_tri_p2", int'(bus.DB), 64);

    repeat (10) @(posedge Clk);
    #1 check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
